// File: rtl/digit_scan_seq_if.sv
// Bus bundle for the digit-strobe sequencer.
// master: conversion source / display consumer side (drives en, eoc, bcd_in, or_in, single).
// slave : sequencer side (drives ds, q, du, busy, ovr).
interface digit_scan_seq_if #(
  parameter int unsigned NDIG = 4,
  parameter int unsigned BW   = 4
);
  logic             en;
  logic             eoc;
  logic [NDIG*BW-1:0] bcd_in;
  logic             or_in;
  logic             single;
  logic [NDIG-1:0]  ds;
  logic [BW-1:0]    q;
  logic             du;
  logic             busy;
  logic             ovr;

  modport master (
    output en, eoc, bcd_in, or_in, single,
    input  ds, q, du, busy, ovr
  );

  modport slave (
    input  en, eoc, bcd_in, or_in, single,
    output ds, q, du, busy, ovr
  );
endinterface

// File: rtl/digit_scan_seq.sv
// Configurable digit-strobe sequencer for the MC14433 display path.
// Latches the conversion result on each accepted end-of-conversion and walks a
// one-hot strobe from MSD to LSD, presenting each digit's code for DIV cycles
// (the last GAP of which are blanked). Continuous or single-shot scanning.
// Ports:
//   clk  - system clock, rising edge
//   R    - asynchronous active-high reset
//   bus  - slave modport: en, eoc, bcd_in, or_in, single in;
//          ds (one-hot strobes), q (digit code), du (update pulse),
//          busy (scan active), ovr (latched overrange) out, all registered.
module digit_scan_seq #(
  parameter int unsigned NDIG = 4,
  parameter int unsigned DIV  = 8,
  parameter int unsigned GAP  = 2,
  parameter int unsigned BW   = 4
) (
  input  logic               clk,
  input  logic               R,
  digit_scan_seq_if.slave    bus
);

  localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DGW     = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned SLOT_ON = DIV - GAP;
  localparam int unsigned HW      = NDIG * BW;

  typedef enum logic {S_IDLE, S_SCAN} state_e;

  state_e          st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DGW-1:0]  dig_q, dig_d;
  logic [HW-1:0]   hold_bcd_q, hold_bcd_d;
  logic            hold_or_q, hold_or_d;
  logic [NDIG-1:0] ds_q, ds_d;
  logic [BW-1:0]   q_q, q_d;
  logic            du_q, du_d;
  logic            busy_q, busy_d;
  logic            acc;

  // eoc is only honoured while enabled
  assign acc = bus.en & bus.eoc;

  // State and output registers
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      st_q       <= S_IDLE;
      cnt_q      <= '0;
      dig_q      <= DGW'(NDIG - 1);
      hold_bcd_q <= '0;
      hold_or_q  <= 1'b0;
      ds_q       <= '0;
      q_q        <= '0;
      du_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      hold_bcd_q <= hold_bcd_d;
      hold_or_q  <= hold_or_d;
      ds_q       <= ds_d;
      q_q        <= q_d;
      du_q       <= du_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state; outputs are derived from the next state so they line up
  // with the counters on the same edge.
  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    dig_d      = dig_q;
    hold_bcd_d = hold_bcd_q;
    hold_or_d  = hold_or_q;
    du_d       = 1'b0;
    ds_d       = '0;
    q_d        = q_q;
    busy_d     = 1'b0;

    if (!bus.en) begin
      st_d  = S_IDLE;
      cnt_d = '0;
      dig_d = DGW'(NDIG - 1);
    end else if (acc) begin
      // restart wins over every other transition, including scan end
      st_d       = S_SCAN;
      cnt_d      = '0;
      dig_d      = DGW'(NDIG - 1);
      hold_bcd_d = bus.bcd_in;
      hold_or_d  = bus.or_in;
      du_d       = 1'b1;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          if (!bus.single) begin
            st_d  = S_SCAN;
            cnt_d = '0;
            dig_d = DGW'(NDIG - 1);
          end
        end
        S_SCAN: begin
          if (cnt_q == CW'(DIV - 1)) begin
            cnt_d = '0;
            if (dig_q != '0) begin
              dig_d = dig_q - DGW'(1);
            end else begin
              // single is only looked at here, at the LSD slot end
              dig_d = DGW'(NDIG - 1);
              if (bus.single) begin
                st_d = S_IDLE;
              end
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: st_d = S_IDLE;
      endcase
    end

    if (st_d == S_SCAN) begin
      busy_d = 1'b1;
      q_d    = hold_bcd_d[BW*32'(dig_d) +: BW];
      if (32'(cnt_d) < SLOT_ON) begin
        ds_d = NDIG'(1) << dig_d;
      end
    end
  end

  assign bus.ds   = ds_q;
  assign bus.q    = q_q;
  assign bus.du   = du_q;
  assign bus.busy = busy_q;
  assign bus.ovr  = hold_or_q;

endmodule
